// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 load/store encodings and the memory-stage FSM states
package riscv_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {MA_IDLE, MA_WAIT, MA_DONE} ma_state_t;
endpackage

// File: rtl/load_formatter.sv
// load_formatter: picks the addressed byte/half from a read word and sign/zero-extends it
module load_formatter
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [31:0] lane;
    assign lane = rdata >> {addr, 3'b000};
    assign result = (funct3 == F3_B)  ? {{24{lane[7]}}, lane[7:0]} :
                    (funct3 == F3_BU) ? {24'h0, lane[7:0]} :
                    (funct3 == F3_H)  ? {{16{lane[15]}}, lane[15:0]} :
                    (funct3 == F3_HU) ? {16'h0, lane[15:0]} : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage valid/ready bus controller with load formatting and pipeline stall
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic        stall,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misaligned,
    output logic        bus_err
);
    ma_state_t   state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] rdata_q, load_data, wdata;
    logic [3:0]  strb;
    logic        err, mem_op, mis, go, tmo;
    assign mem_op = mem_read_in | mem_write_in;
    assign mis = ((funct3_in == F3_H || funct3_in == F3_HU) && alu_result_in[0]) ||
                 (funct3_in == F3_W && alu_result_in[1:0] != 2'b00);
    assign go  = mem_op & ~mis;
    assign tmo = cnt == 8'(TIMEOUT - 1);
    // funct3[1:0] encodes the store size: 00 byte, 01 half, 10 word
    assign strb  = (funct3_in[1:0] == 2'b00) ? 4'b0001 << alu_result_in[1:0] :
                   (funct3_in[1:0] == 2'b01) ? 4'b0011 << alu_result_in[1:0] : 4'b1111;
    assign wdata = (funct3_in[1:0] == 2'b00) ? {4{rs2_data_in[7:0]}} :
                   (funct3_in[1:0] == 2'b01) ? {2{rs2_data_in[15:0]}} : rs2_data_in;
    load_formatter u_fmt (
        .rdata  (rdata_q),
        .addr   (alu_result_in[1:0]),
        .funct3 (funct3_in),
        .result (load_data)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MA_IDLE;
            cnt     <= 8'd0;
            rdata_q <= 32'h0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == MA_WAIT && state_nxt == MA_WAIT) ? cnt + 8'd1 : 8'd0;
            if (state == MA_WAIT && rsp_valid) rdata_q <= rsp_rdata;
            err   <= state == MA_WAIT && !rsp_valid && tmo;
        end
    end
    always_comb begin
        state_nxt    = state;
        req_valid    = 1'b0;
        stall        = 1'b0;
        misaligned   = 1'b0;
        bus_err      = 1'b0;
        req_we       = mem_write_in;
        req_addr     = {alu_result_in[31:2], 2'b00};
        req_wdata    = wdata;
        req_wstrb    = mem_write_in ? strb : 4'b0000;
        wb_result    = alu_result_in;
        wb_rd        = rd_in;
        wb_reg_write = reg_write_in & ~mem_op;
        case (state)
            MA_IDLE: begin
                req_valid  = go;
                stall      = go;
                misaligned = mem_op & mis;
                state_nxt  = (go && req_ready) ? MA_WAIT : MA_IDLE;
            end
            MA_WAIT: begin
                stall     = 1'b1;
                state_nxt = (rsp_valid || tmo) ? MA_DONE : MA_WAIT;
            end
            MA_DONE: begin
                state_nxt    = MA_IDLE;
                bus_err      = err;
                wb_result    = mem_read_in ? load_data : alu_result_in;
                wb_reg_write = reg_write_in & mem_read_in & ~mem_write_in & ~err;
            end
            default: state_nxt = MA_IDLE;
        endcase
        // Outputs are forced quiet for as long as reset is held, including mid-transaction
        if (!reset_n) begin
            req_valid    = 1'b0;
            stall        = 1'b0;
            misaligned   = 1'b0;
            bus_err      = 1'b0;
            req_we       = 1'b0;
            req_addr     = 32'h0;
            req_wdata    = 32'h0;
            req_wstrb    = 4'b0000;
            wb_result    = 32'h0;
            wb_rd        = 5'd0;
            wb_reg_write = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven and randomized checks of the memory-stage controller
module tb_mem_access_unit;
    localparam int TMO = 4;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [31:0] alu_result_in = '0, rs2_data_in = '0, rsp_rdata = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        reg_write_in = 0, mem_read_in = 0, mem_write_in = 0, req_ready = 0, rsp_valid = 0;
    logic        req_valid, req_we, stall, wb_reg_write, misaligned, bus_err;
    logic [31:0] req_addr, req_wdata, wb_result;
    logic [3:0]  req_wstrb;
    logic [4:0]  wb_rd;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .rd_in(rd_in), .funct3_in(funct3_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .stall(stall), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misaligned(misaligned), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw;
        logic [31:0] rdata;
        int          rdly, sdly;   // sdly < 0: bus never answers
        logic [31:0] e_res;
        logic        e_rw;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_mis, e_err;
    } vec_t;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] alu, rs2, input logic [4:0] rd, input logic [2:0] f3,
                                input logic rw, mr, mw, input logic [31:0] rdata, input int rdly, sdly,
                                input logic [31:0] e_res, input logic e_rw, input logic [31:0] e_addr, e_wdata,
                                input logic [3:0] e_wstrb, input logic e_mis, e_err);
        vec_t v;
        v.alu = alu; v.rs2 = rs2; v.rd = rd; v.f3 = f3; v.rw = rw; v.mr = mr; v.mw = mw;
        v.rdata = rdata; v.rdly = rdly; v.sdly = sdly; v.e_res = e_res; v.e_rw = e_rw;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_mis = e_mis; v.e_err = e_err;
        return v;
    endfunction

    function automatic logic m_mis(input logic [31:0] a, input logic [2:0] f3);
        int o = int'(a % 4);
        return ((f3 == 3'd1 || f3 == 3'd5) && (o % 2) != 0) || (f3 == 3'd2 && o != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v = rdata >> (8 * (a % 4));
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end else v = rdata;
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        logic mem = v.mr | v.mw;
        v.e_mis   = mem && m_mis(v.alu, v.f3);
        v.e_err   = mem && !v.e_mis && v.sdly < 0;
        v.e_rw    = !mem ? v.rw : (v.e_mis || v.mw || v.e_err) ? 1'b0 : v.rw;
        v.e_res   = (v.mr && !v.e_mis) ? m_load(v.rdata, v.alu, v.f3) : v.alu;
        v.e_addr  = v.alu - (v.alu % 4);
        v.e_wdata = (v.f3 == 3'd0) ? (v.rs2 % 256) * 32'h01010101 :
                    (v.f3 == 3'd1) ? (v.rs2 % 65536) * 32'h00010001 : v.rs2;
        v.e_wstrb = !v.mw ? 4'h0 : (v.f3 == 3'd0) ? 4'(1 << (v.alu % 4)) :
                    (v.f3 == 3'd1) ? 4'(3 << (v.alu % 4)) : 4'hF;
        return v;
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after the edge that ends the op
    task automatic run_op(input vec_t v, input string tag);
        alu_result_in = v.alu; rs2_data_in = v.rs2; rd_in = v.rd; funct3_in = v.f3;
        reg_write_in = v.rw; mem_read_in = v.mr; mem_write_in = v.mw;
        req_ready = 0; rsp_valid = 0; rsp_rdata = $urandom;
        if (!(v.mr || v.mw) || v.e_mis) begin
            @(negedge clk);
            chk(tag, "stall", 32'(stall), 0);
            chk(tag, "req_valid", 32'(req_valid), 0);
            chk(tag, "misaligned", 32'(misaligned), 32'(v.e_mis));
            chk(tag, "wb_reg_write", 32'(wb_reg_write), 32'(v.e_rw));
            chk(tag, "wb_rd", 32'(wb_rd), 32'(v.rd));
            if (!v.e_mis) chk(tag, "wb_result", wb_result, v.e_res);
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i <= v.rdly; i++) begin
            req_ready = (i == v.rdly);
            rsp_valid = (i != v.rdly) && 1'($urandom_range(0, 1));
            rsp_rdata = $urandom;
            @(negedge clk);
            chk(tag, "req_valid", 32'(req_valid), 1);
            chk(tag, "stall_idle", 32'(stall), 1);
            chk(tag, "req_we", 32'(req_we), 32'(v.mw));
            chk(tag, "req_addr", req_addr, v.e_addr);
            chk(tag, "req_wstrb", 32'(req_wstrb), 32'(v.e_wstrb));
            if (v.mw) chk(tag, "req_wdata", req_wdata, v.e_wdata);
            chk(tag, "wb_reg_write_idle", 32'(wb_reg_write), 0);
            chk(tag, "misaligned_idle", 32'(misaligned), 0);
            @(posedge clk); #1;
        end
        req_ready = 0;
        for (int w = 0; w < TMO; w++) begin
            rsp_valid = (w == v.sdly);
            rsp_rdata = (w == v.sdly) ? v.rdata : $urandom;
            @(negedge clk);
            chk(tag, "stall_wait", 32'(stall), 1);
            chk(tag, "req_valid_wait", 32'(req_valid), 0);
            chk(tag, "bus_err_wait", 32'(bus_err), 0);
            @(posedge clk); #1;
            if (w == v.sdly) break;
        end
        rsp_valid = 1'($urandom_range(0, 1));
        rsp_rdata = $urandom;
        @(negedge clk);
        chk(tag, "stall_done", 32'(stall), 0);
        chk(tag, "req_valid_done", 32'(req_valid), 0);
        chk(tag, "bus_err", 32'(bus_err), 32'(v.e_err));
        chk(tag, "wb_reg_write", 32'(wb_reg_write), 32'(v.e_rw));
        chk(tag, "wb_rd", 32'(wb_rd), 32'(v.rd));
        if (v.mr && !v.e_err) chk(tag, "wb_result", wb_result, v.e_res);
        @(posedge clk); #1;
        rsp_valid = 0;
    endtask

    vec_t tbl[15];

    initial begin
        vec_t v;
        logic [2:0] lf[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        tbl[0]  = mk(32'h1234, 0, 5, 3'd0, 1, 0, 0, 0, 0, 0, 32'h1234, 1, 32'h1234, 0, 4'h0, 0, 0);
        tbl[1]  = mk(32'h1003, 0, 3, 3'd0, 1, 1, 0, 32'h80FF0000, 0, 0, 32'hFFFFFF80, 1, 32'h1000, 0, 4'h0, 0, 0);
        tbl[2]  = mk(32'h1003, 0, 3, 3'd4, 1, 1, 0, 32'h80FF0000, 0, 0, 32'h00000080, 1, 32'h1000, 0, 4'h0, 0, 0);
        tbl[3]  = mk(32'h2002, 32'hAAAABEEF, 4, 3'd1, 1, 0, 1, 0, 3, 0, 0, 0, 32'h2000, 32'hBEEFBEEF, 4'b1100, 0, 0);
        tbl[4]  = mk(32'h3001, 0, 6, 3'd2, 1, 1, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 4'h0, 1, 0);
        tbl[5]  = mk(32'h4000, 0, 8, 3'd2, 1, 1, 0, 0, 0, -1, 0, 0, 32'h4000, 0, 4'h0, 0, 1);
        tbl[6]  = mk(32'h4004, 0, 9, 3'd2, 1, 1, 0, 32'h12345678, 1, TMO - 1, 32'h12345678, 1, 32'h4004, 0, 4'h0, 0, 0);
        tbl[7]  = mk(32'h5002, 0, 10, 3'd1, 1, 1, 0, 32'h80017FFF, 0, 1, 32'hFFFF8001, 1, 32'h5000, 0, 4'h0, 0, 0);
        tbl[8]  = mk(32'h5002, 0, 10, 3'd5, 1, 1, 0, 32'h80017FFF, 0, 1, 32'h00008001, 1, 32'h5000, 0, 4'h0, 0, 0);
        tbl[9]  = mk(32'h6001, 32'h123456A5, 11, 3'd0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h6000, 32'hA5A5A5A5, 4'b0010, 0, 0);
        tbl[10] = mk(32'h7000, 32'hDEADBEEF, 12, 3'd2, 0, 0, 1, 0, 0, 2, 0, 0, 32'h7000, 32'hDEADBEEF, 4'hF, 0, 0);
        tbl[11] = mk(32'h2001, 0, 13, 3'd1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h2000, 0, 4'h0, 1, 0);
        tbl[12] = mk(32'h5001, 0, 14, 3'd5, 1, 1, 0, 0, 0, 0, 0, 0, 32'h5000, 0, 4'h0, 1, 0);
        tbl[13] = mk(32'h0001, 0, 15, 3'd0, 1, 1, 0, 32'h00007F00, 0, 0, 32'h0000007F, 1, 32'h0000, 0, 4'h0, 0, 0);
        tbl[14] = mk(32'hCAFEF00D, 0, 31, 3'd2, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00C, 0, 4'h0, 0, 0);

        // Reset held with an aligned load on the inputs: everything must stay quiet
        alu_result_in = 32'h1000; rd_in = 7; funct3_in = 3'd2; reg_write_in = 1; mem_read_in = 1; req_ready = 1;
        @(negedge clk);
        chk("reset", "req_valid", 32'(req_valid), 0);
        chk("reset", "stall", 32'(stall), 0);
        chk("reset", "wb_reg_write", 32'(wb_reg_write), 0);
        chk("reset", "req_addr", req_addr, 0);
        chk("reset", "wb_result", wb_result, 0);
        chk("reset", "wb_rd", 32'(wb_rd), 0);
        chk("reset", "misaligned", 32'(misaligned), 0);
        chk("reset", "bus_err", 32'(bus_err), 0);
        mem_read_in = 0; reg_write_in = 0; req_ready = 0;
        @(posedge clk); #1;
        reset_n = 1;

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while waiting for the response
        alu_result_in = 32'h8000; rd_in = 9; funct3_in = 3'd2; reg_write_in = 1; mem_read_in = 1; mem_write_in = 0;
        req_ready = 1;
        @(negedge clk);
        chk("midrst", "req_valid", 32'(req_valid), 1);
        @(posedge clk); #1;
        req_ready = 0;
        @(negedge clk);
        chk("midrst", "stall_wait", 32'(stall), 1);
        #1 reset_n = 0;
        #1;
        chk("midrst", "req_valid", 32'(req_valid), 0);
        chk("midrst", "stall", 32'(stall), 0);
        chk("midrst", "wb_reg_write", 32'(wb_reg_write), 0);
        @(posedge clk); #1;
        reset_n = 1;
        run_op(model(mk(32'h8000, 0, 9, 3'd2, 1, 1, 0, 32'h0BADF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "post_rst");

        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 2);
            v = mk($urandom, $urandom, 5'($urandom), 3'($urandom), 1'($urandom), 0, 0, $urandom,
                   $urandom_range(0, 2), 0, 0, 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
            v.sdly = $urandom_range(0, TMO);
            if (v.sdly == TMO) v.sdly = -1;
            if (kind == 1) begin v.mr = 1; v.f3 = lf[$urandom_range(0, 4)]; end
            if (kind == 2) begin v.mw = 1; v.f3 = 3'($urandom_range(0, 2)); end
            run_op(model(v), $sformatf("rnd%0d", n));
        end

        mem_read_in = 0; mem_write_in = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller sitting on the consumer side of the EX/MEM pipeline register. It turns the registered EX/MEM fields (address, store data, rd, control bits) into a valid/ready data-bus transaction and formats load data. It produces the write-back fields for the MEM/WB register, and drives the `stall` that freezes the upstream stages while a bus access is outstanding.

## Interface
Parameters:
- `TIMEOUT`, 255 — WAIT-state cycles before a bus error is declared; 8-bit counter, legal range 1..255.

Ports:
- `clk` in 1 — rising-edge clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `alu_result_in` in 32 — effective address, or non-memory result.
- `rs2_data_in` in 32 — store data.
- `rd_in` in 5 — destination register.
- `funct3_in` in 3 — access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `reg_write_in`, `mem_read_in`, `mem_write_in` in 1 each — control bits from EX/MEM.
- `req_valid` out 1 — bus request valid.
- `req_ready` in 1 — bus accepts request.
- `req_we` out 1 — 1 = store.
- `req_addr` out 32 — word-aligned address ({addr[31:2],2'b00}).
- `req_wdata` out 32 — lane-replicated store data.
- `req_wstrb` out 4 — byte strobes.
- `rsp_valid` in 1 — bus response (read data or write ack).
- `rsp_rdata` in 32 — read data.
- `stall` out 1 — freeze PC/IF/ID/ID-EX/EX-MEM.
- `wb_result` out 32 — value for MEM/WB.
- `wb_rd` out 5 — destination for MEM/WB.
- `wb_reg_write` out 1 — write-enable for MEM/WB.
- `misaligned` out 1 — one-cycle pulse, misaligned access.
- `bus_err` out 1 — one-cycle pulse, bus timeout.

## Operation
- Memory op = `mem_read_in | mem_write_in`. Non-memory op: `wb_result = alu_result_in`, `wb_rd = rd_in`, `wb_reg_write = reg_write_in`, `stall = 0` (all combinational).
- Misaligned when H/HU and addr[0] = 1, or W and addr[1:0] ≠ 0. A misaligned access:
  - issues no request;
  - pulses `misaligned`;
  - forces `wb_reg_write = 0`;
  - keeps `stall = 0`.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 1 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
  - Loads drive wstrb = 0000.
- Load formatting: select byte/half by addr[1:0] from captured rdata; B/H sign-extend, BU/HU zero-extend.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on an aligned memory op, `req_valid = 1` and `stall = 1`, with request fields driven combinationally from the inputs. On `req_ready` go to WAIT; otherwise stay in IDLE, holding the request stable.
  - WAIT: `stall = 1`, `req_valid = 0`, counter increments. On `rsp_valid`: capture rdata, go to DONE. When the counter reaches `TIMEOUT` with no response: set the error flag, go to DONE.
  - DONE: `stall = 0`. Loads present the formatted data on `wb_result` with `wb_reg_write = reg_write_in`. Stores present `wb_reg_write = 0`. On error, `bus_err = 1` and `wb_reg_write = 0`. Always go to IDLE next.
- EX/MEM inputs are stable throughout, because `stall` holds that register.
- A response that arrives in the same cycle as acceptance is not possible. `rsp_valid` is only sampled in WAIT.

## Timing
- Reset values (async): state = IDLE, counter = 0, captured data = 0, error flag = 0.
  - Outputs during reset: `req_valid = 0`, `stall = 0`, `misaligned = 0`, `bus_err = 0`, `wb_reg_write = 0`, `req_addr`/`req_wdata`/`req_wstrb`/`wb_result`/`wb_rd` = 0.
- Minimum memory latency is 3 cycles (IDLE accept, WAIT with rsp, DONE), with 2 stall cycles. Each extra `req_ready` or `rsp_valid` wait cycle adds one cycle.
- The instruction after a memory op is loaded into EX/MEM at the DONE edge and is evaluated in IDLE the next cycle. There is no double issue.
- `rsp_valid` in the same cycle the counter hits `TIMEOUT`: the response wins and no error is raised.
- Stray `rsp_valid` in IDLE or DONE is ignored.
- Reset mid-transaction returns to IDLE at once; `req_valid` drops asynchronously. The bus must tolerate the abandoned request.

## Structure
- Shared package `riscv_pkg`: funct3 load/store encodings and the FSM state enum (`MA_IDLE`, `MA_WAIT`, `MA_DONE`).
- One natural sub-module: `load_formatter`, combinational. Inputs: rdata, addr[1:0], funct3. Output: 32-bit extended result.

## Test plan
- ADD result `0x0000_1234`, rd = 5, reg_write = 1 → same cycle: `wb_result = 0x1234`, `wb_rd = 5`, `wb_reg_write = 1`, `stall = 0`, `req_valid = 0`.
- LB at addr `0x1003`, rdata `0x80FF_0000` returned the cycle after accept → `stall` high 2 cycles; DONE shows `wb_result = 0xFFFF_FF80`. LBU on the same data gives `0x0000_0080`.
- SH at addr `0x2002`, rs2 `0xAAAA_BEEF`, `req_ready` low 3 cycles → request held stable. Then `req_addr = 0x2000`, `wdata = 0xBEEF_BEEF`, `wstrb = 1100`; DONE shows `wb_reg_write = 0`.
- LW at addr `0x3001` → no request, `misaligned` pulses for 1 cycle, `wb_reg_write = 0`, `stall = 0`.
- LW with no `rsp_valid` and `TIMEOUT = 4` → 4 WAIT cycles, then DONE with `bus_err = 1` and `wb_reg_write = 0`, then back to IDLE.
- `reset_n` asserted during WAIT → `req_valid`, `stall`, and `wb_reg_write` are 0 immediately. After release, a fresh LW completes normally.
